// File: rtl/tile_renderer.sv
// tile_renderer: map-tile and robot-sprite colour stage with 2-cycle aligned VGA output
module tile_renderer #(
    parameter int TILE_COLS = 20,
    parameter int TILE_ROWS = 15,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic       clock_25,
    input  logic       reset_key,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [4:0] robot_tile_x,
    input  logic [3:0] robot_tile_y,
    input  logic [1:0] robot_dir,
    input  logic       robot_valid,
    output logic [8:0] map_addr,
    input  logic [2:0] map_data,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    function automatic logic in_rng(input logic [4:0] v, input logic [4:0] lo, input logic [4:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic        active_in, latch;
    logic [4:0]  ox_d, ox_q, oy_d, oy_q, tx_d, tx_q;
    logic [3:0]  ty_d, ty_q;
    logic        von1_d, von1_q, hs1_d, hs1_q, vs1_d, vs1_q;
    logic [4:0]  sx_d, sx_q;
    logic [3:0]  sy_d, sy_q;
    logic [1:0]  sdir_d, sdir_q;
    logic        sv_d, sv_q;
    logic        fs_d, fs_q;
    logic [23:0] tile_rgb, rgb_d, rgb_q;
    logic        hs2_d, hs2_q, vs2_d, vs2_q;
    logic        hit, body, mark;

    // Map address from the incoming pixel; clamped to 0 outside the visible area
    always_comb begin
        active_in = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
        map_addr  = active_in ? 9'(pixel_y[8:5]) * 9'(TILE_COLS) + 9'(pixel_x[9:5]) : 9'd0;
        latch     = (pixel_y == 10'(V_ACTIVE)) && (pixel_x == 10'd0);
    end

    // Stage 1 capture and frame-latched robot shadow
    always_comb begin
        ox_d   = pixel_x[4:0];
        oy_d   = pixel_y[4:0];
        tx_d   = pixel_x[9:5];
        ty_d   = pixel_y[8:5];
        von1_d = video_on;
        hs1_d  = hsync_in;
        vs1_d  = vsync_in;
        sx_d   = latch ? robot_tile_x : sx_q;
        sy_d   = latch ? robot_tile_y : sy_q;
        sdir_d = latch ? robot_dir : sdir_q;
        sv_d   = latch ? robot_valid : sv_q;
        fs_d   = latch;
    end

    // Stage 2 colour: palette lookup, sprite overlay, blanking
    always_comb begin
        case (map_data)
            3'd0:    tile_rgb = 24'h202020;
            3'd1:    tile_rgb = 24'h808080;
            3'd2:    tile_rgb = 24'h0080FF;
            3'd3:    tile_rgb = 24'h805010;
            default: tile_rgb = 24'hFF00FF;
        endcase
        hit  = sv_q && (sx_q < 5'(TILE_COLS)) && (sy_q < 4'(TILE_ROWS)) && (tx_q == sx_q) && (ty_q == sy_q);
        body = in_rng(ox_q, 5'd4, 5'd27) && in_rng(oy_q, 5'd4, 5'd27);
        case (sdir_q)
            2'd0:    mark = in_rng(oy_q, 5'd4, 5'd11) && in_rng(ox_q, 5'd12, 5'd19);
            2'd1:    mark = in_rng(ox_q, 5'd20, 5'd27) && in_rng(oy_q, 5'd12, 5'd19);
            2'd2:    mark = in_rng(oy_q, 5'd20, 5'd27) && in_rng(ox_q, 5'd12, 5'd19);
            default: mark = in_rng(ox_q, 5'd4, 5'd11) && in_rng(oy_q, 5'd12, 5'd19);
        endcase
        rgb_d = !von1_q       ? 24'h000000 :
                (hit && mark) ? 24'hFF0000 :
                (hit && body) ? 24'hFFFF00 : tile_rgb;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    // Pipeline and shadow registers with synchronous active-low reset
    always_ff @(posedge clock_25) begin
        if (!reset_key) begin
            ox_q   <= '0;
            oy_q   <= '0;
            tx_q   <= '0;
            ty_q   <= '0;
            von1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            sx_q   <= '0;
            sy_q   <= '0;
            sdir_q <= '0;
            sv_q   <= 1'b0;
            fs_q   <= 1'b0;
            rgb_q  <= '0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            tx_q   <= tx_d;
            ty_q   <= ty_d;
            von1_q <= von1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            sdir_q <= sdir_d;
            sv_q   <= sv_d;
            fs_q   <= fs_d;
            rgb_q  <= rgb_d;
            hs2_q  <= hs2_d;
            vs2_q  <= vs2_d;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: directed checks of addressing, latency, palette, sprite and frame latch
module tb_tile_renderer;

    logic       clock_25 = 1'b0;
    logic       reset_key;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, hsync_in, vsync_in;
    logic [4:0] robot_tile_x;
    logic [3:0] robot_tile_y;
    logic [1:0] robot_dir;
    logic       robot_valid;
    logic [8:0] map_addr;
    logic [2:0] map_data = 3'd0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start;
    logic [2:0] ram [0:299];
    int         checks = 0;
    int         errors = 0;

    tile_renderer dut (
        .clock_25(clock_25), .reset_key(reset_key), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .robot_tile_x(robot_tile_x), .robot_tile_y(robot_tile_y), .robot_dir(robot_dir),
        .robot_valid(robot_valid), .map_addr(map_addr), .map_data(map_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .frame_start(frame_start)
    );

    always #20 clock_25 = ~clock_25;

    // Synchronous map RAM model: data one cycle after address
    always @(posedge clock_25) map_data <= ram[map_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic fill(input logic [2:0] code);
        for (int i = 0; i < 300; i++) ram[i] = code;
    endtask

    task automatic drive(input int x, input int y, input logic von, input logic hs, input logic vs);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic pchk(input string tag, input int x, input int y, input logic [23:0] exp);
        drive(x, y, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk(tag, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp});
    endtask

    task automatic latch_robot(input logic [4:0] x, input logic [3:0] y, input logic [1:0] d, input logic v);
        robot_tile_x = x;
        robot_tile_y = y;
        robot_dir    = d;
        robot_valid  = v;
        drive(0, 480, 1'b0, 1'b1, 1'b1);
        tick();
        chk("frame_start_pulse", 32'(frame_start), 32'd1);
        drive(1, 480, 1'b0, 1'b1, 1'b1);
        tick();
        chk("frame_start_end", 32'(frame_start), 32'd0);
    endtask

    initial begin
        reset_key    = 1'b0;
        robot_tile_x = 5'd0;
        robot_tile_y = 4'd0;
        robot_dir    = 2'd0;
        robot_valid  = 1'b0;
        fill(3'd1);
        drive(100, 37, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        chk("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("reset_hs", 32'(vga_hs), 32'd1);
        chk("reset_vs", 32'(vga_vs), 32'd1);
        chk("reset_fs", 32'(frame_start), 32'd0);
        reset_key = 1'b1;
        tick();
        chk("post_rel1_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("post_rel1_hs", 32'(vga_hs), 32'd1);
        tick();
        chk("post_rel2_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h808080);
        chk("post_rel2_hs", 32'(vga_hs), 32'd0);
        chk("post_rel2_vs", 32'(vga_vs), 32'd0);

        fill(3'd2);
        ram[25] = 3'd1;
        for (int i = 0; i < 642; i++) begin
            drive(i, 37, i < 640, 1'b1, 1'b1);
            #1;
            if (i < 640) chk("sweep_addr", 32'(map_addr), 32'(20 + i / 32));
            tick();
            if (i >= 1 && i <= 640)
                chk("sweep_rgb", {8'h0, vga_r, vga_g, vga_b},
                    (i - 1 >= 160 && i - 1 < 192) ? 32'h808080 : 32'h0080FF);
        end

        fill(3'd1);
        drive(10, 37, 1'b0, 1'b0, 1'b1);
        tick();
        chk("hs_delay1", 32'(vga_hs), 32'd1);
        drive(11, 37, 1'b0, 1'b1, 1'b1);
        tick();
        chk("hs_delay2", 32'(vga_hs), 32'd0);
        chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        tick();
        chk("hs_restore", 32'(vga_hs), 32'd1);

        fill(3'd0);
        latch_robot(5'd5, 4'd3, 2'd1, 1'b1);
        pchk("marker_right", 184, 111, 24'hFF0000);
        pchk("body", 164, 100, 24'hFFFF00);
        pchk("robot_tile_map", 161, 97, 24'h202020);
        pchk("body_edge27", 187, 100, 24'hFFFF00);
        pchk("body_edge28", 188, 100, 24'h202020);
        robot_tile_x = 5'd6;
        pchk("no_latch_old_pos", 184, 111, 24'hFF0000);
        pchk("no_latch_new_pos", 216, 111, 24'h202020);
        latch_robot(5'd5, 4'd3, 2'd0, 1'b1);
        pchk("marker_up", 176, 100, 24'hFF0000);
        pchk("up_body", 176, 120, 24'hFFFF00);
        latch_robot(5'd5, 4'd3, 2'd2, 1'b1);
        pchk("marker_down", 176, 123, 24'hFF0000);
        latch_robot(5'd5, 4'd3, 2'd3, 1'b1);
        pchk("marker_left", 164, 112, 24'hFF0000);
        pchk("left_body", 184, 111, 24'hFFFF00);

        drive(184, 111, 1'b1, 1'b1, 1'b1);
        reset_key = 1'b0;
        tick();
        chk("midframe_reset_black", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        reset_key = 1'b1;
        pchk("robot_gone_after_reset", 184, 111, 24'h202020);

        latch_robot(5'd25, 4'd3, 2'd1, 1'b1);
        pchk("robot_x_oob", 184, 111, 24'h202020);
        latch_robot(5'd5, 4'd3, 2'd1, 1'b0);
        pchk("robot_invalid", 184, 111, 24'h202020);

        fill(3'd5);
        pchk("invalid_code", 10, 10, 24'hFF00FF);
        fill(3'd3);
        pchk("dirty_pipe", 639, 479, 24'h805010);

        drive(639, 479, 1'b1, 1'b1, 1'b1);
        #1;
        chk("addr_last", 32'(map_addr), 32'd299);
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        #1;
        chk("addr_clamp", 32'(map_addr), 32'd0);
        drive(639, 480, 1'b0, 1'b1, 1'b1);
        #1;
        chk("addr_clamp_y", 32'(map_addr), 32'd0);
        drive(0, 32, 1'b1, 1'b1, 1'b1);
        #1;
        chk("addr_row1", 32'(map_addr), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
